// File: rtl/serial_add_8bit.sv
// Bit-serial adder, LSB first: rebuilds minuend = difference + subtrahend.
// Start/busy/done handshake; sum and carry_out update only on completion.
module serial_add_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s_d;
  logic             c_d;
  logic [WIDTH-1:0] res_d;
  logic             last_d;

  // One full-adder slice on the current LSBs plus the carry flop.
  always_comb begin
    s_d    = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    c_d    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
    res_d  = {s_d, res_q[WIDTH-1:1]};
    last_d = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM and datapath registers; busy/done track the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      res_q     <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
            busy    <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
          res_q  <= res_d;
          c_q    <= c_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_d) begin
            sum       <= res_d;
            carry_out <= c_d;
            state_q   <= DONE;
            done      <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_8bit.sv
// Directed self-checking bench for serial_add_8bit (WIDTH = 8).
module tb_serial_add_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry_out;

  int checks = 0;
  int errors = 0;

  serial_add_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from IDLE; optional mid-SHIFT start/operand disturbance.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input bit disturb,
                       output logic [7:0] got);
    logic [8:0] exp;
    logic [7:0] prev_sum;
    logic       prev_c;
    int         cyc;
    int         bad;
    exp      = {1'b0, ta} + {1'b0, tb_v};
    prev_sum = sum;
    prev_c   = carry_out;
    bad      = 0;
    a        = ta;
    b        = tb_v;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 20) begin
      if (!busy || sum !== prev_sum || carry_out !== prev_c) bad++;
      if (disturb && cyc == 3) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
      end
      if (disturb && cyc == 6) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'd8);
    check("busy_hold", 32'(bad), 32'd0);
    check("sum", 32'(sum), 32'(exp[7:0]));
    check("carry", 32'(carry_out), 32'(exp[8]));
    check("busy_at_done", 32'(busy), 32'd0);
    got = sum;
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] xa;
    logic [7:0] xb;
    int         cyc;
    int         d1;
    int         d2;
    int         nd;

    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and carry boundary vectors.
    do_op(8'h03, 8'h08, 1'b0, got);
    check("v03_08", 32'(got), 32'h0B);
    do_op(8'hFF, 8'h01, 1'b0, got);
    check("vFF_01", 32'(got), 32'h00);
    check("vFF_01_c", 32'(carry_out), 32'd1);
    do_op(8'h80, 8'h80, 1'b0, got);
    check("v80_80", 32'(got), 32'h00);
    check("v80_80_c", 32'(carry_out), 32'd1);
    do_op(8'h7F, 8'h01, 1'b0, got);
    check("v7F_01", 32'(got), 32'h80);
    check("v7F_01_c", 32'(carry_out), 32'd0);

    // Back-to-back with start held high; operands swapped on done.
    a     = 8'h05;
    b     = 8'h03;
    start = 1'b1;
    cyc   = 0;
    d1    = -1;
    d2    = -1;
    while (d2 < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc;
          check("b2b_sum1", 32'(sum), 32'h08);
          a = 8'h09;
          b = 8'h03;
        end else begin
          d2 = cyc;
          check("b2b_sum2", 32'(sum), 32'h0C);
          start = 1'b0;
        end
      end
    end
    check("b2b_first", 32'(d1), 32'd9);
    check("b2b_space", 32'(d2 - d1), 32'd9);
    @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);
    check("b2b_nodone", 32'(done), 32'd0);

    // Start and operand changes during SHIFT are ignored.
    do_op(8'h0C, 8'h03, 1'b1, got);
    check("disturb", 32'(got), 32'h0F);

    // Reset at bit 4 aborts the operation.
    a     = 8'h33;
    b     = 8'h44;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    nd    = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_nodone", 32'(nd), 32'd0);
    do_op(8'h0F, 8'h08, 1'b0, got);
    check("after_abort", 32'(got), 32'h17);

    // Sweep of operand pairs plus subtractor round trip (a-b)+b == a.
    for (int i = 0; i < 256; i += 3) begin
      xa = 8'(i);
      xb = 8'((i * 37 + 11) & 255);
      do_op(xa, xb, 1'b0, got);
      do_op(xa - xb, xb, 1'b0, got);
      check("round_trip", 32'(got), 32'(xa));
    end
    do_op(8'hFF, 8'hFF, 1'b0, got);
    check("vFF_FF", 32'(got), 32'hFE);
    check("vFF_FF_c", 32'(carry_out), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
